// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
// Module      : constants_pkg
// Description : Shared numeric constants for the multiply scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package constants_pkg;

   // Cycles from operand issue to result write-back.
   localparam int MUL_LATENCY = 5;

   // Width of an architectural register index.
   localparam int REG_ADDR_W  = 5;

endpackage
`default_nettype wire

// File: rtl/structure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : structure_pkg
// Description : Shared data structures and helpers for the multiply scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package structure_pkg;
   import constants_pkg::*;

   // One stage of the in-flight tracking pipeline.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dst;
      logic                  owner;
   } mul_slot_t;

   // Register x0 is hard-wired, so it never creates a dependency.
   function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] r,
                                    input logic [REG_ADDR_W-1:0] d);
      return (r != '0) && (r == d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_rr_arbiter
// Description : Two-way round-robin arbiter with a 1-bit priority pointer.
//               The pointer moves to the other requester after any grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] elig_i,
   output logic [1:0] grant_o,
   output logic       sel_o
);

   logic ptr_q;
   logic ptr_d;

   // Grant selection: pointer breaks ties, a lone eligible requester always wins.
   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         if (elig_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
         end else begin
            grant_o = elig_i;
         end
      end
      sel_o = grant_o[1];
      ptr_d = ptr_q;
      if (|grant_o) begin
         ptr_d = ~grant_o[1];
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched
// Description : Schedules two requesters onto one pipelined multiplier.
//               Tracks in-flight destinations in a fixed-latency slot
//               pipeline, blocks requesters with register hazards and
//               arbitrates round-robin among the rest.
//               Optional statistics counters: define MUL_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sched
   import constants_pkg::*;
   import structure_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i [0:1],
   input  logic [REG_ADDR_W-1:0] req_dst_i   [0:1],
   input  logic [REG_ADDR_W-1:0] req_src1_i  [0:1],
   input  logic [REG_ADDR_W-1:0] req_src2_i  [0:1],
   input  logic                  flush_i,
   output logic [1:0]            grant_o,
   output logic                  mul_issue_o,
   output logic                  mul_sel_o,
   output logic                  wb_valid_o,
   output logic [REG_ADDR_W-1:0] wb_dst_o,
   output logic                  wb_owner_o,
   output logic [31:0]           stat_issued_o,
   output logic [31:0]           stat_stall_o
);

   mul_slot_t slot_q [MUL_LATENCY];
   mul_slot_t slot_d [MUL_LATENCY];
   logic [1:0] hazard;
   logic [1:0] elig;
   logic       arb_sel;

   // Hazard check against every valid slot, including the one writing back now.
   always_comb begin
      hazard = 2'b00;
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < MUL_LATENCY; s++) begin
            if (slot_q[s].valid &&
                (reg_hit(req_src1_i[r], slot_q[s].dst) ||
                 reg_hit(req_src2_i[r], slot_q[s].dst) ||
                 reg_hit(req_dst_i[r],  slot_q[s].dst))) begin
               hazard[r] = 1'b1;
            end
         end
      end
   end

   generate
      for (genvar r = 0; r < 2; r++) begin : g_elig
         assign elig[r] = req_valid_i[r] & ~hazard[r];
      end
   endgenerate

   // Nothing is granted while in reset or during a flush.
   mul_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .en_i    (~rst & ~flush_i),
      .elig_i  (elig),
      .grant_o (grant_o),
      .sel_o   (arb_sel)
   );

   assign mul_issue_o = |grant_o;
   assign mul_sel_o   = arb_sel;

   // Slot pipeline next state: new grant enters stage 0, flush empties everything.
   always_comb begin
      slot_d[0].valid = mul_issue_o;
      slot_d[0].dst   = mul_issue_o ? req_dst_i[arb_sel] : '0;
      slot_d[0].owner = mul_issue_o & arb_sel;
      for (int s = 1; s < MUL_LATENCY; s++) begin
         slot_d[s] = slot_q[s-1];
      end
      if (flush_i) begin
         for (int s = 0; s < MUL_LATENCY; s++) begin
            slot_d[s] = '0;
         end
      end
   end

   // Slot pipeline register, shifted every cycle (multiplier never stalls).
   always_ff @(posedge clk) begin
      for (int s = 0; s < MUL_LATENCY; s++) begin
         if (rst) begin
            slot_q[s] <= '0;
         end else begin
            slot_q[s] <= slot_d[s];
         end
      end
   end

   assign wb_valid_o = slot_q[MUL_LATENCY-1].valid & ~rst;
   assign wb_dst_o   = wb_valid_o ? slot_q[MUL_LATENCY-1].dst : '0;
   assign wb_owner_o = wb_valid_o & slot_q[MUL_LATENCY-1].owner;

`ifdef MUL_SCHED_STATS_EN
   logic [31:0] issued_q;
   logic [31:0] issued_d;
   logic [31:0] stall_q;
   logic [31:0] stall_d;
   logic        stall;

   // A flush cycle is a deliberate kill, not a stall, so it is not counted.
   always_comb begin
      stall    = ~flush_i & ((req_valid_i[0] & ~grant_o[0]) |
                             (req_valid_i[1] & ~grant_o[1]));
      issued_d = issued_q + {31'd0, mul_issue_o};
      stall_d  = stall_q + {31'd0, stall};
   end

   // Statistics registers, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign stat_issued_o = issued_q;
   assign stat_stall_o  = stall_q;
`else
   assign stat_issued_o = '0;
   assign stat_stall_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sched
// Description : Self-checking bench for mul_sched against an event-history
//               reference model (grants recorded per cycle, kills by
//               flush/reset, results due MUL_LATENCY cycles after grant).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sched;
   import constants_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;
   logic        req_valid [0:1];
   logic [4:0]  req_dst   [0:1];
   logic [4:0]  req_src1  [0:1];
   logic [4:0]  req_src2  [0:1];
   logic [1:0]  grant_o;
   logic        mul_issue_o;
   logic        mul_sel_o;
   logic        wb_valid_o;
   logic [4:0]  wb_dst_o;
   logic        wb_owner_o;
   logic [31:0] stat_issued_o;
   logic [31:0] stat_stall_o;

   mul_sched dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_dst_i    (req_dst),
      .req_src1_i   (req_src1),
      .req_src2_i   (req_src2),
      .flush_i      (flush),
      .grant_o      (grant_o),
      .mul_issue_o  (mul_issue_o),
      .mul_sel_o    (mul_sel_o),
      .wb_valid_o   (wb_valid_o),
      .wb_dst_o     (wb_dst_o),
      .wb_owner_o   (wb_owner_o),
      .stat_issued_o(stat_issued_o),
      .stat_stall_o (stat_stall_o)
   );

   int nchk  = 0;
   int npass = 0;
   int nfail = 0;

   // Reference history: what was granted in each cycle and which cycles killed the pipe.
   bit         m_vld  [0:4095];
   logic [4:0] m_dst  [0:4095];
   bit         m_own  [0:4095];
   bit         m_kill [0:4095];
   int         t;
   bit         m_ptr;
   logic [31:0] m_issued;
   logic [31:0] m_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
      end
   endtask

   // An op granted at cycle c is visible in cycles c+1..c+LAT unless a kill came in between.
   function automatic bit alive(input int c, input int now);
      if (c < 0) return 1'b0;
      if (!m_vld[c] || now <= c || now > c + MUL_LATENCY) return 1'b0;
      for (int f = c + 1; f < now; f++) begin
         if (m_kill[f]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit hit(input logic [4:0] r, input logic [4:0] d);
      return (r != 5'd0) && (r == d);
   endfunction

   function automatic bit haz(input int r);
      for (int c = t - MUL_LATENCY; c < t; c++) begin
         if (alive(c, t) && (hit(req_src1[r], m_dst[c]) || hit(req_src2[r], m_dst[c]) ||
                             hit(req_dst[r], m_dst[c])))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   // One clock cycle: predict, compare at negedge, record, advance.
   task automatic step();
      bit e0, e1, en, stl, wbv;
      logic [1:0] g;
      int wc;
      @(negedge clk);
      e0 = req_valid[0] && !haz(0);
      e1 = req_valid[1] && !haz(1);
      en = !rst && !flush;
      g  = 2'b00;
      if (en) begin
         if (e0 && e1) g = m_ptr ? 2'b10 : 2'b01;
         else          g = {e1, e0};
      end
      wc  = t - MUL_LATENCY;
      wbv = !rst && alive(wc, t);
      chk("grant",    {30'd0, grant_o},    {30'd0, g});
      chk("issue",    {31'd0, mul_issue_o}, {31'd0, |g});
      chk("sel",      {31'd0, mul_sel_o},   {31'd0, g[1]});
      chk("wb_valid", {31'd0, wb_valid_o},  {31'd0, wbv});
      chk("wb_dst",   {27'd0, wb_dst_o},    wbv ? {27'd0, m_dst[wc]} : 32'd0);
      chk("wb_owner", {31'd0, wb_owner_o},  {31'd0, wbv && m_own[wc]});
`ifdef MUL_SCHED_STATS_EN
      chk("stat_issued", stat_issued_o, m_issued);
      chk("stat_stall",  stat_stall_o,  m_stall);
`else
      chk("stat_issued", stat_issued_o, 32'd0);
      chk("stat_stall",  stat_stall_o,  32'd0);
`endif
      m_vld[t]  = |g;
      m_dst[t]  = g[1] ? req_dst[1] : (g[0] ? req_dst[0] : 5'd0);
      m_own[t]  = g[1];
      m_kill[t] = rst || flush;
      stl = en && ((req_valid[0] && !g[0]) || (req_valid[1] && !g[1]));
      if (|g) m_ptr = ~g[1];
      if (rst) begin
         m_ptr = 1'b0; m_issued = '0; m_stall = '0;
      end else begin
         m_issued = m_issued + {31'd0, |g};
         m_stall  = m_stall + {31'd0, stl};
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic set_req(input int r, input bit v, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2);
      req_valid[r] = v; req_dst[r] = d; req_src1[r] = s1; req_src2[r] = s2;
   endtask

   task automatic idle(input int n);
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      flush = 0; rst = 0;
      repeat (n) step();
   endtask

   initial begin
      rst = 1; flush = 0; t = 0; m_ptr = 0; m_issued = '0; m_stall = '0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      step();                                  // reset state
      rst = 0;

      // Single request, result five cycles later.
      set_req(0, 1, 3, 1, 2); step();
      idle(7);

      // Both requesters, independent registers, fresh from reset: 01,10,01,10.
      rst = 1; step(); rst = 0;
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1, 5'(10 + 2*k), 5'(24 + k), 0);
         set_req(1, 1, 5'(11 + 2*k), 5'(28 + k), 0);
         step();
      end
      idle(7);

      // RAW hazard: req1 waits for dst=5 to drain.
      set_req(0, 1, 5, 0, 0); step();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 1, 9, 5, 0);
      repeat (6) step();
      idle(7);

      // Three grants then a flush with a waiting requester.
      for (int k = 0; k < 3; k++) begin
         set_req(0, 1, 5'(1 + k), 0, 0); step();
      end
      set_req(0, 0, 0, 0, 0);
      set_req(1, 1, 12, 1, 0);
      flush = 1; step(); flush = 0;
      set_req(1, 0, 0, 0, 0);
      idle(7);

      // Reset with two ops in flight.
      set_req(0, 1, 6, 0, 0); step();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 1, 7, 0, 0); step();
      rst = 1; step();
      idle(7);

      // x0 is never a dependency.
      set_req(0, 1, 0, 0, 0); step();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 1, 0, 0, 0); repeat (2) step();
      idle(6);

      // Random traffic with small register range to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < 2; r++)
            set_req(r, ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         flush = ($urandom_range(0, 23) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         step();
      end
      idle(6);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports req_valid_i[0:1], input, 1 each, requester N presents a multiply.
REQ-004 SHALL have ports req_dst_i[0:1], input, 5 each, destination register of requester N.
REQ-005 SHALL have ports req_src1_i[0:1] and req_src2_i[0:1], input, 5 each, source registers of requester N.
REQ-006 SHALL have port grant_o, output, 2, one-hot grant, combinational in the request cycle.
REQ-007 SHALL have port mul_issue_o, output, 1, operands enter the multiplier this cycle.
REQ-008 SHALL have port mul_sel_o, output, 1, index of the requester whose operands the multiplier input mux selects.
REQ-009 SHALL have port flush_i, input, 1, kills all in-flight operations.
REQ-010 SHALL have ports wb_valid_o (1), wb_dst_o (5) and wb_owner_o (1), outputs, describing the result leaving the multiplier.
REQ-011 SHALL have ports stat_issued_o and stat_stall_o, output, 32 each, statistics counters.

Function
REQ-012 SHALL grant at most one requester per cycle; mul_issue_o = |grant_o; mul_sel_o = granted index, 0 when idle.
REQ-013 SHALL treat a requester as eligible when valid and free of hazards.
REQ-014 SHALL flag a hazard when any nonzero src1/src2/dst of the requester equals the dst of any valid in-flight slot, including the slot writing back this cycle; x0 is never tracked.
REQ-015 SHALL arbitrate round-robin: when both requesters are eligible, grant the one named by a 1-bit priority pointer; after any grant the pointer moves to the other requester.
REQ-016 SHALL grant a single eligible requester regardless of the pointer.
REQ-017 SHALL track in-flight operations in a MUL_LATENCY-deep shift register of {valid, dst, owner}, shifted every cycle; the multiplier has no backpressure.
REQ-018 SHALL assert wb_valid_o exactly MUL_LATENCY (5) cycles after the grant cycle, with wb_dst_o/wb_owner_o taken from the granted request; wb_dst_o = 0 and wb_owner_o = 0 when wb_valid_o = 0.
REQ-019 SHALL, on flush_i, clear every slot valid bit on the next edge; wb_valid_o SHALL be 0 from the next cycle until new grants emerge, and grant_o SHALL be 0 in the flush cycle.
REQ-020 SHALL not block a grant because of a same-cycle grant to the other requester; that hazard is visible from the next cycle.

Reset
REQ-021 SHALL, on rst, clear all slots, set the pointer to 0 and clear both counters; grant_o, mul_issue_o, mul_sel_o and wb_* SHALL read 0 while rst is high.
REQ-022 SHALL give rst priority over flush_i and requests; in-flight results at reset are discarded.

Configuration
REQ-023 SHALL compile the counters only when MUL_SCHED_STATS_EN is defined: stat_issued_o increments per grant and stat_stall_o per cycle with any valid but ungranted requester; both wrap at 2^32.
REQ-024 SHALL, without MUL_SCHED_STATS_EN, keep both stat ports and drive them constant 0.

Structure
REQ-025 SHALL take MUL_LATENCY (=5) and REG_ADDR_W (=5) from constants_pkg and a mul_slot_t {valid, dst, owner} typedef from structure_pkg.
REQ-026 SHALL instantiate one sub-module, mul_rr_arbiter (2-way round-robin with pointer), and implement the slot pipeline and hazard compare in mul_sched.

Verification
REQ-027 SHALL pass: req0 dst=3 src=1,2 at cycle 0, no other traffic -> grant_o=01 at cycle 0; wb_valid_o=1, wb_dst_o=3, wb_owner_o=0 at cycle 5 only.
REQ-028 SHALL pass: both requesters valid, independent regs, for 4 cycles after reset -> grants 01,10,01,10.
REQ-029 SHALL pass: req0 dst=5 granted at cycle 0, req1 src1=5 from cycle 1 -> req1 stalled in cycles 1-5, granted at cycle 6.
REQ-030 SHALL pass: three grants at cycles 0-2, flush_i at cycle 3 -> no wb_valid_o in cycles 4-8, and stat_stall_o counts only genuinely stalled cycles.
REQ-031 SHALL pass: rst asserted at cycle 2 with two ops in flight -> all outputs 0 next cycle, no wb_valid_o afterwards, counters 0.
REQ-032 SHALL pass: a request with dst=0 and src=0 behind an in-flight dst=0 -> granted with no stall.
